// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence-capture block.
package seq_pkg;

  // Default sample width of the upstream sequence generator.
  localparam int SEQ_WIDTH = 32;

  // Capture FSM states.
  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    CAPTURE    = 2'd1,
    HALT       = 2'd2
  } state_t;

  // One generator sample.
  typedef logic [SEQ_WIDTH-1:0] seq_t;

endpackage : seq_pkg

// File: rtl/seq_fifo.sv
// First-word-fall-through FIFO with a registered head.
// Full/empty come from the occupancy count, never from pointer equality.
module seq_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_head;

  logic             w_empty;
  logic             w_full;
  logic             w_rd;
  logic             w_wr;
  logic [PTR_W-1:0] w_rd_ptr_inc;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_empty      = (r_level == LVL_W'(0));
  assign w_full       = (r_level == LVL_W'(DEPTH));
  assign w_rd         = pop & ~w_empty;
  assign w_wr         = push & (~w_full | w_rd);
  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

  // Next head: the following entry after a pop, or the incoming word when
  // it is the only thing left in (or entering) the FIFO; otherwise hold.
  always_comb begin
    w_head_nxt = r_head;
    if (w_rd) begin
      if (r_level > LVL_W'(1)) begin
        w_head_nxt = r_mem[w_rd_ptr_inc];
      end else if (w_wr) begin
        w_head_nxt = push_data;
      end else begin
        w_head_nxt = r_head;
      end
    end else if (w_wr && w_empty) begin
      w_head_nxt = push_data;
    end else begin
      w_head_nxt = r_head;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      if (w_wr && !w_rd) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_rd && !w_wr) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

  assign head  = r_head;
  assign empty = w_empty;
  assign full  = w_full;
  assign level = r_level;

endmodule : seq_fifo

// File: rtl/seq_capture.sv
// Consumer of the free-running sequence generator: drops the post-reset
// leading zero, detects 32-bit wrap (a decrease of a non-decreasing
// sequence), buffers accepted samples and streams them out valid/ready.
module seq_capture
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           seq_i,
  input  logic                       en_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic                       wrap_o
);

  state_t           r_state;
  state_t           w_state_cand;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_prev;
  logic             r_wrap;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_push_req;
  logic             w_prev_upd;
  logic             w_set_wrap;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;

  // Capture decision: enable first, then per-state sample qualification.
  always_comb begin
    w_push_req   = 1'b0;
    w_prev_upd   = 1'b0;
    w_set_wrap   = 1'b0;
    w_state_cand = r_state;
    if (!en_i) begin
      w_state_cand = WAIT_FIRST;
    end else begin
      case (r_state)
        WAIT_FIRST: begin
          if (seq_i != '0) begin
            w_push_req   = 1'b1;
            w_prev_upd   = 1'b1;
            w_state_cand = CAPTURE;
          end else begin
            w_state_cand = WAIT_FIRST;
          end
        end
        CAPTURE: begin
          if (seq_i >= r_prev) begin
            w_push_req   = 1'b1;
            w_prev_upd   = 1'b1;
            w_state_cand = CAPTURE;
          end else begin
            w_set_wrap   = 1'b1;
            w_state_cand = HALT;
          end
        end
        HALT: begin
          w_state_cand = HALT;
        end
        default: begin
          w_state_cand = WAIT_FIRST;
        end
      endcase
    end
  end

  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign w_pop       = ~w_empty & ready_i;
  assign w_accept    = w_push_req & (~w_full | w_pop);
  assign w_drop      = w_push_req & w_full & ~w_pop;
  // A dropped sample leaves the FSM where it was.
  assign w_state_nxt = w_drop ? r_state : w_state_cand;

  // FSM state, last-seen sample, sticky wrap flag and saturating drop count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= WAIT_FIRST;
      r_prev     <= '0;
      r_wrap     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_prev_upd) begin
        r_prev <= seq_i;
      end
      if (w_set_wrap) begin
        r_wrap <= 1'b1;
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  seq_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_accept),
    .push_data (seq_i),
    .pop       (w_pop),
    .head      (data_o),
    .empty     (w_empty),
    .full      (w_full),
    .level     (level_o)
  );

  assign valid_o    = ~w_empty;
  assign drop_cnt_o = r_drop_cnt;
  assign wrap_o     = r_wrap;

endmodule : seq_capture

// File: tb/tb_seq_capture.sv
// Directed self-checking bench for seq_capture (DEPTH=8, CNT_W=4).
module tb_seq_capture;

  logic        clk;
  logic        reset;
  logic [31:0] seq_i;
  logic        en_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  level_o;
  logic [3:0]  drop_cnt_o;
  logic        wrap_o;

  int n_cmp;
  int n_err;

  // Generator output after reset, then its continuation.
  logic [31:0] gen_a [16];
  logic [31:0] gen_b [9];
  logic [31:0] drain_exp [9];

  seq_capture #(
    .WIDTH (32),
    .DEPTH (8),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seq_i      (seq_i),
    .en_i       (en_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .drop_cnt_o (drop_cnt_o),
    .wrap_o     (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    gen_a = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd4,
              32'd5, 32'd7, 32'd9, 32'd12, 32'd16, 32'd21, 32'd28, 32'd37};
    gen_b = '{32'd21, 32'd28, 32'd37, 32'd49, 32'd65, 32'd86, 32'd114, 32'd151, 32'd200};
    drain_exp = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd4, 32'd5, 32'd21, 32'd28};
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    en_i    = 1'b0;
    seq_i   = 32'd0;
    ready_i = 1'b1;

    // Reset state.
    #1 reset = 1'b1;
    #2;
    check_val("rst_data",  data_o, 32'd0);
    check_val("rst_valid", {31'd0, valid_o}, 32'd0);
    check_val("rst_level", {28'd0, level_o}, 32'd0);
    check_val("rst_drop",  {28'd0, drop_cnt_o}, 32'd0);
    check_val("rst_wrap",  {31'd0, wrap_o}, 32'd0);
    tick;
    reset = 1'b0;

    // Streaming with ready high: leading zero discarded, latency one.
    en_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      seq_i = gen_a[k];
      tick;
      if (k == 0) begin
        check_val("s1_lead0_valid", {31'd0, valid_o}, 32'd0);
      end else begin
        check_val("s1_valid", {31'd0, valid_o}, 32'd1);
        check_val("s1_data", data_o, gen_a[k]);
        check_val("s1_level", {28'd0, level_o}, 32'd1);
      end
    end
    check_val("s1_drop", {28'd0, drop_cnt_o}, 32'd0);
    check_val("s1_wrap", {31'd0, wrap_o}, 32'd0);

    // Back-pressure: fill to 8, drop 4, head holds.
    pulse_reset;
    ready_i = 1'b0;
    for (int k = 0; k < 13; k++) begin
      seq_i = gen_a[k];
      tick;
      if (k > 0) begin
        check_val("s2_hold_data", data_o, 32'd1);
      end
    end
    check_val("s2_level", {28'd0, level_o}, 32'd8);
    check_val("s2_drop", {28'd0, drop_cnt_o}, 32'd4);

    // Drain while full: every live sample accepted, level stays 8.
    ready_i = 1'b1;
    for (int j = 0; j < 9; j++) begin
      seq_i = gen_b[j];
      tick;
      check_val("s2_drain_data", data_o, drain_exp[j]);
      check_val("s2_drain_level", {28'd0, level_o}, 32'd8);
      if (j == 0) begin
        check_val("s2_full_pop_drop", {28'd0, drop_cnt_o}, 32'd4);
      end
    end

    // Wrap detection and HALT.
    pulse_reset;
    ready_i = 1'b1;
    seq_i = 32'hFFFF_FFF0;
    tick;
    check_val("s3_first_data", data_o, 32'hFFFF_FFF0);
    check_val("s3_first_wrap", {31'd0, wrap_o}, 32'd0);
    seq_i = 32'h0000_0010;
    tick;
    check_val("s3_wrap", {31'd0, wrap_o}, 32'd1);
    check_val("s3_wrap_level", {28'd0, level_o}, 32'd0);
    seq_i = 32'hFFFF_FFFF;
    tick;
    check_val("s3_halt_level", {28'd0, level_o}, 32'd0);
    en_i  = 1'b0;
    seq_i = 32'h0000_0030;
    tick;
    check_val("s3_dis_level", {28'd0, level_o}, 32'd0);
    check_val("s3_dis_wrap", {31'd0, wrap_o}, 32'd1);
    en_i  = 1'b1;
    seq_i = 32'd5;
    tick;
    check_val("s3_restart_valid", {31'd0, valid_o}, 32'd1);
    check_val("s3_restart_data", data_o, 32'd5);
    check_val("s3_restart_wrap", {31'd0, wrap_o}, 32'd1);

    // Asynchronous reset mid-stream with 5 entries buffered.
    ready_i = 1'b0;
    for (int v = 6; v < 10; v++) begin
      seq_i = 32'(v);
      tick;
    end
    check_val("s4_level", {28'd0, level_o}, 32'd5);
    check_val("s4_head", data_o, 32'd5);
    #2 reset = 1'b1;
    #1;
    check_val("s4_async_valid", {31'd0, valid_o}, 32'd0);
    check_val("s4_async_level", {28'd0, level_o}, 32'd0);
    check_val("s4_async_drop", {28'd0, drop_cnt_o}, 32'd0);
    check_val("s4_async_wrap", {31'd0, wrap_o}, 32'd0);
    #1 reset = 1'b0;
    seq_i = 32'd0;
    tick;
    check_val("s4_zero_valid", {31'd0, valid_o}, 32'd0);
    tick;
    check_val("s4_zero2_valid", {31'd0, valid_o}, 32'd0);
    seq_i = 32'd7;
    tick;
    check_val("s4_first_valid", {31'd0, valid_o}, 32'd1);
    check_val("s4_first_data", data_o, 32'd7);

    // Drop counter saturation (4-bit counter): 7 fills, then 20 drops.
    for (int i = 0; i < 27; i++) begin
      seq_i = 32'(8 + i);
      tick;
      if (i == 20) begin
        check_val("s5_drop14", {28'd0, drop_cnt_o}, 32'd14);
      end
      if (i == 21) begin
        check_val("s5_drop15", {28'd0, drop_cnt_o}, 32'd15);
      end
    end
    check_val("s5_sat", {28'd0, drop_cnt_o}, 32'd15);
    check_val("s5_level", {28'd0, level_o}, 32'd8);
    check_val("s5_head", data_o, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_capture

// File: doc/seq_capture.md
Name: seq_capture

Overview:
Downstream consumer of the free-running 32-bit sequence generator output. It samples the generator value every cycle and discards the post-reset leading zero. It detects 32-bit wrap-around, which shows up as a decrease of a non-decreasing sequence. Accepted values are buffered in a small FIFO and presented on a valid/ready stream to the next stage.

Parameters:
WIDTH, 32, sample/data width
DEPTH, 8, FIFO entries (power of two, >=2)
CNT_W, 16, drop-counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
seq_i  in  WIDTH  generator output, sampled every posedge
en_i  in  1  capture enable
data_o  out  WIDTH  FIFO head value
valid_o  out  1  data_o valid (FIFO not empty)
ready_i  in  1  downstream accept; pop when valid_o & ready_i
level_o  out  $clog2(DEPTH+1)  FIFO occupancy
drop_cnt_o  out  CNT_W  samples lost to full FIFO, saturating
wrap_o  out  1  sticky wrap-detected flag

Behaviour:
- One clock; reset is asynchronous and active-high. While reset is high: data_o=0, valid_o=0, level_o=0, drop_cnt_o=0, wrap_o=0, state=WAIT_FIRST, prev=0, FIFO pointers cleared.
- FSM states: WAIT_FIRST, CAPTURE, HALT. Evaluate en_i first, in every state.
- Any state, en_i=0: go to WAIT_FIRST, no push. wrap_o and prev are unchanged.
- WAIT_FIRST, en_i=1, seq_i!=0: push seq_i, prev<=seq_i, go to CAPTURE.
- WAIT_FIRST, en_i=1, seq_i==0: stay, no push.
- CAPTURE, en_i=1, seq_i>=prev (unsigned; equal is legal): push seq_i, prev<=seq_i.
- CAPTURE, en_i=1, seq_i<prev: wrap. wrap_o<=1, no push, go to HALT.
- HALT: no pushes. Leaves only via en_i=0.
- wrap_o is cleared only by reset.
- Push acceptance: accept if FIFO not full, OR if full and a pop occurs in the same cycle. A push arriving when full with no pop is dropped.
- On a drop: drop_cnt_o increments by 1 and saturates at all-ones. prev still updates, so wrap detection follows the live sequence.
- A dropped sample does not change state.
- FIFO is first-word-fall-through. A sample pushed at edge N into an empty FIFO gives valid_o=1 and data_o=sample after edge N (latency 1).
- data_o holds its value while valid_o=1 and ready_i=0.
- Pop on empty is ignored.
- level_o: +1 on accepted push only, -1 on pop only, unchanged on simultaneous push+pop. Range 0..DEPTH.
- Pointers wrap modulo DEPTH. Full/empty are derived from level, not from pointer equality.
- data_o while empty is don't-care; the implementation drives the last head value.
- Reset asserted mid-stream discards FIFO contents immediately, with no drain.

Decomposition:
- Package seq_pkg:
  - WIDTH default constant
  - typedef enum for state_t {WAIT_FIRST, CAPTURE, HALT}
  - typedef logic [WIDTH-1:0] seq_t
- One sub-module: seq_fifo.
  - Synchronous FWFT FIFO, parameterised WIDTH/DEPTH.
  - Ports: push, push_data, pop, head, empty, full, level.
  - Same clk/reset convention.
- seq_capture contains the FSM, compare/prev register, drop counter and wrap flag.

Test Plan:
- Generator driving seq_i after reset (0,1,1,1,2,2,3,4,5,7,9,12,...), en_i=1, ready_i=1 -> data_o stream 1,1,1,2,2,3,4,5,7,9,12; 0 never appears; drop_cnt_o=0; wrap_o=0.
- Same stimulus, ready_i=0 for first 12 accepted samples (DEPTH=8) -> level_o=8 holding 1,1,1,2,2,3,4,5; drop_cnt_o=4. Then ready_i=1 -> drains 1,1,1,2,2,3,4,5, then continues with the current live values.
- Direct drive seq_i=0xFFFF_FFF0 then 0x0000_0010 -> wrap_o=1 next cycle; 0x10 not pushed; state HALT; later values not pushed. Then en_i=0 for one cycle, en_i=1, seq_i=5 -> 5 pushed; wrap_o stays 1.
- FIFO full (level_o=8), ready_i=1, new valid sample -> sample accepted; level_o stays 8; drop_cnt_o unchanged; head advances by one entry.
- level_o=5, assert reset asynchronously mid-cycle -> valid_o=0, level_o=0, drop_cnt_o=0, wrap_o=0 before the next clock edge. After release, first pushed value is the first nonzero seq_i.
- CNT_W=4, FIFO held full with ready_i=0 for 20 further samples -> drop_cnt_o saturates at 15 and stays 15.
